ica_dca_ctrl: RTL and testbench
===============================

Name: ica_dca_ctrl

Overview:
- Display-channel instruction sequencer (ICA) for the MCD212-style video controller.
- After reset it fetches 32-bit control instructions from video RAM through a simple request/acknowledge read port.
- It decodes each instruction and issues internal register writes, instruction-pointer jumps and video-start-register (VSR) reloads.
- Its register-write port feeds the CLUT/region/cursor register file; its VSR output feeds the display file decoder.

Parameters:
- ICA_START, 22'h000400, byte address of the first instruction fetched after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  out  22  byte address of the current memory read; bit 0 is always 0.
- as  out  1  read request (address strobe).
- din  in  16  read data; valid in the cycle bus_ack=1.
- bus_ack  in  1  read acknowledge, single-cycle pulse.
- register_adr  out  7  target register of a register-load instruction.
- register_data  out  24  data of a register-load instruction.
- register_write  out  1  one-cycle write strobe for register_adr/register_data.
- reload_vsr  out  1  one-cycle strobe: vsr holds a new display-file start address.
- vsr  out  22  video start register value.

Behaviour:
- Reset (reset=0, asynchronous):
  - address=ICA_START; as=0; register_adr=0; register_data=0; register_write=0; reload_vsr=0; vsr=0.
  - Internal instruction pointer IP=ICA_START; state=FETCH_HI.
  - Reset asserted mid-operation aborts any fetch immediately; as drops with reset.
- Memory handshake:
  - Drive address and set as=1, holding both stable until a cycle with bus_ack=1.
  - In that cycle, capture din and set as=0 on the next edge.
  - as stays 0 for at least one cycle between consecutive requests.
  - bus_ack while as=0 is ignored.
  - Unbounded wait for bus_ack, no timeout.
- Instruction fetch:
  - Instructions are big-endian 32-bit words.
  - FETCH_HI reads IP and captures bits [31:16].
  - FETCH_LO reads IP+2 and captures bits [15:0].
  - Then go to EXEC.
  - IP advances by 4 per instruction, wrapping modulo 2^22.
- EXEC: one cycle; decode on instr[31:28]. Unlisted codes act as NOP.
  - 1xxx, register load:
    - register_adr=instr[30:24], register_data=instr[23:0], register_write=1 for exactly one cycle.
    - register_adr/register_data keep their values afterwards.
    - Continue to FETCH_HI.
  - 0000, STOP: go to HALT.
  - 0001, NOP: continue.
  - 0010, RELOAD DCP: internal DCP=instr[21:0] (not otherwise used); continue.
  - 0011, RELOAD DCP + STOP: internal DCP=instr[21:0]; go to HALT.
  - 0100, RELOAD ICA pointer: IP=instr[21:0] with bit 0 forced to 0; continue fetching from the new IP.
  - 0101, RELOAD VSR + STOP: vsr=instr[21:0] with bit 0 forced to 0; reload_vsr=1 for exactly one cycle, coincident with vsr taking its new value; go to HALT.
  - 0110, INTERRUPT: no effect; continue.
  - 0111, RELOAD DISPLAY PARAMETERS: no effect; continue.
- HALT:
  - as=0; no further fetches until the next reset.
  - vsr holds its last value.
- register_write and reload_vsr are never asserted in the same cycle; both are 0 outside EXEC.
- Minimum instruction period with a one-cycle-latency memory: 5 cycles.

Test Plan:
- Reset release with memory word 0x400=16'h8012, 0x402=16'h3456, 0x404=16'h0000 -> first as=1 at address 0x400; one register_write pulse with register_adr=7'h00, register_data=24'h123456; then fetch 0x404 and HALT with as permanently 0.
- Sequence C0 FF 00 FF, AF 80 00 00, 50 01 23 45 at 0x400 -> writes 7'h40 = 24'hFF00FF, then 7'h2F = 24'h800000; reload_vsr pulses once with vsr=22'h012344; no fetch follows.
- 0x400 holds 40 00 08 00; 0x800 holds 9F 00 00 01, 00 00 00 00 -> after the jump the next fetch address is 0x800; write 7'h1F = 24'h000001; HALT.
- Memory delaying bus_ack by 5 cycles -> address and as stay stable for the whole wait; the captured instruction is unchanged; no extra writes occur.
- Reset pulsed low while as=1 mid-program -> all outputs return to their reset values asynchronously; after release, fetching restarts at 0x400.
- NOP, INTERRUPT (0x60000000) and RELOAD DCP (0x20001234) before a register load -> no strobes from the first three; the register load executes normally at address 0x40C.

Source files
------------

// File: rtl/ica_dca_ctrl.sv
// ica_dca_ctrl: display-channel instruction sequencer (ICA).
// Fetches big-endian 32-bit control instructions from video RAM over a
// request/acknowledge read port, then decodes them into register writes,
// instruction-pointer jumps and video-start-register reloads.
// Each fetch half is a two-phase sequence: raise the strobe, then wait for
// the acknowledge. The idle phase guarantees at least one as=0 cycle
// between consecutive requests.
module ica_dca_ctrl #(
    parameter logic [21:0] ICA_START = 22'h000400
) (
    input  logic        clk,
    input  logic        reset,
    output logic [21:0] address,
    output logic        as,
    input  logic [15:0] din,
    input  logic        bus_ack,
    output logic [6:0]  register_adr,
    output logic [23:0] register_data,
    output logic        register_write,
    output logic        reload_vsr,
    output logic [21:0] vsr
);

    // Opcodes decoded from instr[31:28]; 1xxx is a register load.
    localparam logic [3:0] OP_STOP      = 4'b0000;
    localparam logic [3:0] OP_DCP       = 4'b0010;
    localparam logic [3:0] OP_DCP_STOP  = 4'b0011;
    localparam logic [3:0] OP_JUMP      = 4'b0100;
    localparam logic [3:0] OP_VSR_STOP  = 4'b0101;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        EXEC     = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t      state_q;
    logic [21:0] ip_q;
    logic [21:0] address_q;
    logic        as_q;
    logic [15:0] instr_hi_q;
    logic [3:0]  op_q;
    logic [21:0] arg_q;
    logic [21:0] dcp_q;
    logic [6:0]  register_adr_q;
    logic [23:0] register_data_q;
    logic        register_write_q;
    logic        reload_vsr_q;
    logic [21:0] vsr_q;

    logic [31:0] instr_s;
    logic [21:0] ip_next_d;
    logic [21:0] ip_lo_addr_d;
    logic        unused_dcp_s;

    // Full instruction as seen in the cycle the low half is acknowledged.
    assign instr_s      = {instr_hi_q, din};
    // Sequential instruction pointer and low-half fetch address.
    assign ip_next_d    = ip_q + 22'd4;
    assign ip_lo_addr_d = ip_q + 22'd2;
    // The display-control pointer is kept for the display path but has
    // no consumer inside this block.
    assign unused_dcp_s = ^dcp_q;

    // Sequencer FSM: fetch handshake, decode, and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= FETCH_HI;
            ip_q             <= {ICA_START[21:1], 1'b0};
            address_q        <= {ICA_START[21:1], 1'b0};
            as_q             <= 1'b0;
            instr_hi_q       <= 16'h0000;
            op_q             <= 4'h0;
            arg_q            <= 22'h000000;
            dcp_q            <= 22'h000000;
            register_adr_q   <= 7'h00;
            register_data_q  <= 24'h000000;
            register_write_q <= 1'b0;
            reload_vsr_q     <= 1'b0;
            vsr_q            <= 22'h000000;
        end else begin
            // Strobes are single-cycle; they only rise on entry to EXEC.
            register_write_q <= 1'b0;
            reload_vsr_q     <= 1'b0;
            case (state_q)
                FETCH_HI: begin
                    if (!as_q) begin
                        address_q <= ip_q;
                        as_q      <= 1'b1;
                    end else if (bus_ack) begin
                        instr_hi_q <= din;
                        as_q       <= 1'b0;
                        state_q    <= FETCH_LO;
                    end else begin
                        as_q <= 1'b1;
                    end
                end
                FETCH_LO: begin
                    if (!as_q) begin
                        address_q <= ip_lo_addr_d;
                        as_q      <= 1'b1;
                    end else if (bus_ack) begin
                        as_q    <= 1'b0;
                        op_q    <= instr_s[31:28];
                        arg_q   <= instr_s[21:0];
                        state_q <= EXEC;
                        // Outputs are registered here so the strobes are
                        // visible exactly during the EXEC cycle.
                        if (instr_s[31]) begin
                            register_write_q <= 1'b1;
                            register_adr_q   <= instr_s[30:24];
                            register_data_q  <= instr_s[23:0];
                        end else if (instr_s[31:28] == OP_VSR_STOP) begin
                            reload_vsr_q <= 1'b1;
                            vsr_q        <= {instr_s[21:1], 1'b0};
                        end else begin
                            reload_vsr_q <= 1'b0;
                        end
                    end else begin
                        as_q <= 1'b1;
                    end
                end
                EXEC: begin
                    as_q <= 1'b0;
                    case (op_q)
                        OP_STOP: begin
                            state_q <= HALT;
                        end
                        OP_DCP: begin
                            dcp_q   <= arg_q;
                            ip_q    <= ip_next_d;
                            state_q <= FETCH_HI;
                        end
                        OP_DCP_STOP: begin
                            dcp_q   <= arg_q;
                            state_q <= HALT;
                        end
                        OP_JUMP: begin
                            ip_q    <= {arg_q[21:1], 1'b0};
                            state_q <= FETCH_HI;
                        end
                        OP_VSR_STOP: begin
                            state_q <= HALT;
                        end
                        default: begin
                            // Register load, NOP, interrupt, display
                            // parameters and unlisted codes all continue.
                            ip_q    <= ip_next_d;
                            state_q <= FETCH_HI;
                        end
                    endcase
                end
                HALT: begin
                    as_q    <= 1'b0;
                    state_q <= HALT;
                end
                default: begin
                    as_q    <= 1'b0;
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign address        = address_q;
    assign as             = as_q;
    assign register_adr   = register_adr_q;
    assign register_data  = register_data_q;
    assign register_write = register_write_q;
    assign reload_vsr     = reload_vsr_q;
    assign vsr            = vsr_q;

endmodule

// File: tb/tb_ica_dca_ctrl.sv
// Scoreboard bench for ica_dca_ctrl: a memory responder serves reads,
// expected fetch addresses and strobe events are queued by the stimulus,
// and a monitor compares them as the DUT presents them.
module tb_ica_dca_ctrl;

    typedef struct packed {
        logic        is_vsr;
        logic [6:0]  adr;
        logic [23:0] dat;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [21:0] address;
    logic        as;
    logic [15:0] din;
    logic        bus_ack;
    logic [6:0]  register_adr;
    logic [23:0] register_data;
    logic        register_write;
    logic        reload_vsr;
    logic [21:0] vsr;

    logic [15:0] mem [logic [21:0]];
    ev_t         exp_ev[$];
    logic [21:0] exp_fetch[$];
    int          lat;
    int          n_checks;
    int          n_fail;

    ica_dca_ctrl #(.ICA_START(22'h000400)) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .as             (as),
        .din            (din),
        .bus_ack        (bus_ack),
        .register_adr   (register_adr),
        .register_data  (register_data),
        .register_write (register_write),
        .reload_vsr     (reload_vsr),
        .vsr            (vsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put32(input logic [21:0] a, input logic [31:0] w);
        mem[a]          = w[31:16];
        mem[a + 22'd2]  = w[15:0];
    endtask

    task automatic exp_write(input logic [6:0] a, input logic [23:0] d);
        ev_t e;
        e.is_vsr = 1'b0; e.adr = a; e.dat = d;
        exp_ev.push_back(e);
    endtask

    task automatic exp_vsr(input logic [21:0] v);
        ev_t e;
        e.is_vsr = 1'b1; e.adr = 7'h00; e.dat = {2'b00, v};
        exp_ev.push_back(e);
    endtask

    task automatic exp_fetches(input logic [21:0] base, input int n_instr);
        for (int i = 0; i < n_instr; i++) begin
            exp_fetch.push_back(base + 22'(4 * i));
            exp_fetch.push_back(base + 22'(4 * i + 2));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_address"}, {10'h0, address}, 32'h00000400);
        check({tag, "_as"}, {31'h0, as}, 32'h0);
        check({tag, "_register_adr"}, {25'h0, register_adr}, 32'h0);
        check({tag, "_register_data"}, {8'h0, register_data}, 32'h0);
        check({tag, "_register_write"}, {31'h0, register_write}, 32'h0);
        check({tag, "_reload_vsr"}, {31'h0, reload_vsr}, 32'h0);
        check({tag, "_vsr"}, {10'h0, vsr}, 32'h0);
    endtask

    task automatic begin_test;
        reset = 1'b0;
        @(negedge clk);
        mem.delete();
        exp_ev.delete();
        exp_fetch.delete();
    endtask

    task automatic release_reset;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic end_test(input string tag, input int cycles, input logic [21:0] exp_v);
        int busy;
        repeat (cycles) @(negedge clk);
        check({tag, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
        check({tag, "_events_left"}, 32'(exp_ev.size()), 32'd0);
        check({tag, "_vsr_final"}, {10'h0, vsr}, {10'h0, exp_v});
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (as) busy++;
        end
        check({tag, "_halt_as_idle"}, 32'(busy), 32'd0);
    endtask

    // Memory responder: acknowledges a request after lat idle cycles.
    initial begin
        int wait_cnt;
        bus_ack  = 1'b0;
        din      = 16'h0000;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0;
                din     = 16'h0000;
            end else if (as && reset) begin
                if (wait_cnt >= lat) begin
                    bus_ack  = 1'b1;
                    din      = mem.exists(address) ? mem[address] : 16'h0000;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compares fetch addresses, address stability and strobes.
    initial begin
        logic        as_prev;
        logic [21:0] addr_prev;
        ev_t         e;
        as_prev   = 1'b0;
        addr_prev = 22'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (register_write && reload_vsr)
                    check("both_strobes", 32'd1, 32'd0);
                if (as && !as_prev) begin
                    if (exp_fetch.size() == 0)
                        check("unexpected_fetch", {10'h0, address}, 32'hFFFFFFFF);
                    else
                        check("fetch_addr", {10'h0, address}, {10'h0, exp_fetch.pop_front()});
                end
                if (as && as_prev)
                    check("addr_stable", {10'h0, address}, {10'h0, addr_prev});
                if (register_write) begin
                    if (exp_ev.size() == 0) begin
                        check("unexpected_write", {1'b0, register_adr, register_data}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_ev.pop_front();
                        check("write_kind", {31'h0, e.is_vsr}, 32'd0);
                        check("write_adr", {25'h0, register_adr}, {25'h0, e.adr});
                        check("write_data", {8'h0, register_data}, {8'h0, e.dat});
                    end
                end
                if (reload_vsr) begin
                    if (exp_ev.size() == 0) begin
                        check("unexpected_vsr", {10'h0, vsr}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_ev.pop_front();
                        check("vsr_kind", {31'h0, e.is_vsr}, 32'd1);
                        check("vsr_value", {10'h0, vsr}, {8'h0, e.dat});
                    end
                end
            end
            as_prev   = as;
            addr_prev = address;
        end
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        bit found;
        n_checks = 0;
        n_fail   = 0;
        lat      = 0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("init");

        // Single register load then STOP.
        begin_test;
        put32(22'h400, 32'h80123456);
        put32(22'h404, 32'h00000000);
        exp_fetches(22'h400, 2);
        exp_write(7'h00, 24'h123456);
        release_reset;
        end_test("t1", 60, 22'h000000);

        // Two loads then VSR reload + STOP.
        begin_test;
        put32(22'h400, 32'hC0FF00FF);
        put32(22'h404, 32'hAF800000);
        put32(22'h408, 32'h50012345);
        exp_fetches(22'h400, 3);
        exp_write(7'h40, 24'hFF00FF);
        exp_write(7'h2F, 24'h800000);
        exp_vsr(22'h012344);
        release_reset;
        end_test("t2", 60, 22'h012344);
        check("t2_adr_held", {25'h0, register_adr}, 32'h2F);
        check("t2_data_held", {8'h0, register_data}, 32'h800000);

        // Instruction pointer jump.
        begin_test;
        put32(22'h400, 32'h40000800);
        put32(22'h800, 32'h9F000001);
        put32(22'h804, 32'h00000000);
        exp_fetch.push_back(22'h400);
        exp_fetch.push_back(22'h402);
        exp_fetches(22'h800, 2);
        exp_write(7'h1F, 24'h000001);
        release_reset;
        end_test("t3", 60, 22'h000000);

        // Slow memory: acknowledge after 5 waiting cycles.
        begin_test;
        lat = 5;
        put32(22'h400, 32'h80123456);
        put32(22'h404, 32'h00000000);
        exp_fetches(22'h400, 2);
        exp_write(7'h00, 24'h123456);
        release_reset;
        end_test("t4", 100, 22'h000000);
        lat = 0;

        // Asynchronous reset while a fetch is outstanding.
        begin_test;
        put32(22'h400, 32'hC0FF00FF);
        put32(22'h404, 32'h00000000);
        exp_fetches(22'h400, 1);
        exp_fetch.push_back(22'h404);
        exp_write(7'h40, 24'hFF00FF);
        release_reset;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (as && address == 22'h404) found = 1'b1;
        end
        check("t5_reached_fetch", {31'h0, found}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("t5_async");
        check("t5_events_before", 32'(exp_ev.size()), 32'd0);
        exp_fetch.delete();
        exp_fetches(22'h400, 2);
        exp_write(7'h40, 24'hFF00FF);
        release_reset;
        end_test("t5", 60, 22'h000000);

        // NOP, interrupt and DCP reload ahead of a register load.
        begin_test;
        put32(22'h400, 32'h10000000);
        put32(22'h404, 32'h60000000);
        put32(22'h408, 32'h20001234);
        put32(22'h40C, 32'h85ABCDEF);
        put32(22'h410, 32'h00000000);
        exp_fetches(22'h400, 5);
        exp_write(7'h05, 24'hABCDEF);
        release_reset;
        end_test("t6", 80, 22'h000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
